// File: rtl/spi_slave_rx_pkg.sv
// Shared definitions for the SPI receive stage.
// - SPI_MODE   : SPI mode handled by this receiver (mode 0).
// - state_t    : receiver FSM states.
// - DATA_W_DEF : default SPI word width.
package spi_slave_rx_pkg;

  localparam int unsigned SPI_MODE   = 0;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through receive FIFO.
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   push        write request, push_data is the word to store
//   pop_req     read request; honoured only when not empty
//   rd_data     head word (0 while empty), rd_valid = not empty
//   count       words held, 0..FIFO_DEPTH
//   full, empty occupancy status
//   drop        pulses when a push is refused because the FIFO is full
module rx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [DATA_W-1:0]             push_data,
  input  logic                          pop_req,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          drop
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;
  logic              wr;

  assign empty    = (count == '0);
  assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign pop  = pop_req && !empty;
  assign wr   = push && (!full || pop);
  assign drop = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 receiver: oversamples sclk/mosi/cs, assembles MSB-first words
// and buffers them in a FWFT FIFO.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   sclk, mosi, cs  SPI pins from the master (cs active-low), asynchronous
//   rd_en           pop request from the consumer
//   clr_flags       synchronous clear of frame_err / overflow
//   rd_data         FIFO head word, valid while rd_valid
//   rd_valid        FIFO not empty
//   fifo_count      words held
//   busy            frame in progress
//   frame_err       sticky: frame ended with a partial word
//   overflow        sticky: word completed while FIFO full
module spi_slave_rx
  import spi_slave_rx_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sclk,
  input  logic                          mosi,
  input  logic                          cs,
  input  logic                          rd_en,
  input  logic                          clr_flags,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic                   sclk_d;

  logic                   sclk_s;
  logic                   mosi_s;
  logic                   cs_s;
  logic                   sclk_rise;

  state_t                 state;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-1:0]      shift_reg;
  logic [DATA_W-1:0]      word_next;
  logic                   complete;
  logic                   push;
  logic                   err_set;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s && !sclk_d;

  assign word_next = {shift_reg[DATA_W-2:0], mosi_s};
  assign complete  = sclk_rise && (bit_cnt == CNT_W'(DATA_W-1));
  assign push      = (state == SHIFT) && complete;
  // A completing edge coinciding with cs rising counts as a clean end;
  // any other pending or just-arrived bit is a partial word.
  assign err_set   = (state == SHIFT) && cs_s && !complete &&
                     ((bit_cnt != '0) || sclk_rise);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (clr_flags) begin
        frame_err <= 1'b0;
        overflow  <= 1'b0;
      end
      if (err_set) frame_err <= 1'b1;
      if (drop)    overflow  <= 1'b1;

      case (state)
        IDLE: begin
          if (!cs_s) begin
            state     <= SHIFT;
            bit_cnt   <= '0;
            shift_reg <= '0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_reg <= word_next;
            bit_cnt   <= complete ? '0 : bit_cnt + CNT_W'(1);
          end
          if (cs_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (word_next),
    .pop_req   (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (drop)
  );

endmodule
